stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
Central sequencer for the stopwatch datapath. It takes the debounced button pulses, the debounced mode switches and the timebase tick enables, and runs an IDLE/RUN/PAUSED/ADJUST state machine. From that state it issues single-cycle increment/clear strobes to the min:sec counter and a digit blank mask to the display multiplexer. It replaces ad-hoc pause toggling at top level with one synchronous owner of run state.

Parameters:
STOP_AT_MAX, 1, when 1 a run tick arriving with at_max=1 is suppressed and the FSM drops to PAUSED; when 0 the counter is allowed to wrap 59:59->00:00.

Ports:
clk  in  1  master clock; every tick input is a one-cycle enable in this domain.
rst  in  1  synchronous, active-high reset.
pause_pulse  in  1  one-cycle debounced start/stop press.
clear_pulse  in  1  one-cycle debounced reset press.
adj  in  1  debounced ADJ switch level.
sel  in  1  debounced SEL switch level: 0 = minutes, 1 = seconds.
tick_run  in  1  1 Hz enable.
tick_adj  in  1  2 Hz enable.
tick_blink  in  1  blink-rate enable.
at_max  in  1  counter currently shows 59:59.
cnt_tick  out  1  increment seconds with carry into minutes.
cnt_adj_min  out  1  increment minutes field only; no carry.
cnt_adj_sec  out  1  increment seconds field only; no carry.
cnt_clr  out  1  clear counter to 00:00.
running  out  1  state==RUN.
state  out  2  current state encoding, for debug.
blink_mask  out  4  per-anode blank, 1=blank; bit3 is the leftmost digit.

Behaviour:
- All outputs are registered. Each strobe appears exactly 1 cycle after the qualifying input cycle and lasts 1 cycle.
- Reset: state=IDLE, blink_phase=0, and every output is 0 in the cycle after rst is sampled high. The counter is reset by the same rst; there is no cnt_clr on reset.
- At most one of cnt_tick/cnt_adj_min/cnt_adj_sec/cnt_clr is high in any cycle.
- Per-cycle priority: rst > clear_pulse > adj > pause_pulse > ticks.
- States: IDLE=0, RUN=1, PAUSED=2, ADJUST=3.
- clear_pulse, from any state: cnt_clr=1 next cycle. Next state is ADJUST if adj=1, else IDLE. Any tick in the same cycle is dropped.
- adj=1 in IDLE, RUN or PAUSED: go to ADJUST; a tick_run in that cycle is dropped.
- ADJUST with adj=0: go to PAUSED (never directly to RUN).
- IDLE: pause_pulse goes to RUN. tick_run is ignored.
- RUN:
  - tick_run gives cnt_tick.
  - pause_pulse goes to PAUSED.
  - pause_pulse together with tick_run: the tick is honoured AND the FSM goes to PAUSED.
  - If STOP_AT_MAX=1, at_max=1 and tick_run=1: no cnt_tick; go to PAUSED.
- PAUSED: pause_pulse goes to RUN. A tick_run in the same cycle is not honoured; the first increment comes on the next tick_run.
- ADJUST:
  - tick_adj gives cnt_adj_min if sel=0, else cnt_adj_sec.
  - sel is sampled on the tick cycle only, so mid-adjust sel changes take effect at the next tick.
  - pause_pulse is ignored.
  - Field wrap (59->00) is handled by the counter.
- blink_phase:
  - Toggles on tick_blink.
  - Forced to 0 on any state change, so the display is visible immediately on entering a state.
- blink_mask when blink_phase=1:
  - ADJUST with sel=0: 1100.
  - ADJUST with sel=1: 0011.
  - PAUSED: 1111.
  - RUN or IDLE: 0000.
- blink_mask is 0000 whenever blink_phase=0.
- blink_mask tracks the current sel in the same cycle's registered update.
- running = (next state == RUN), registered together with state.

Decomposition:
- stopwatch_pkg holds:
  - the state encoding constants (IDLE/RUN/PAUSED/ADJUST);
  - the mask constants MASK_NONE=0000, MASK_MIN=1100, MASK_SEC=0011, MASK_ALL=1111.
- One natural sub-module, ctrl_blink: blink_phase register with toggle on tick_blink and synchronous clear on a state-change pulse. It outputs blink_phase.
- FSM, strobe generation and mask selection stay in stopwatch_ctrl.

Test Plan:
- rst held 2 cycles, then pause_pulse, then 3 tick_run spaced 10 cycles apart: state goes 0->1 one cycle after the pulse; 3 cnt_tick pulses, each 1 cycle after its tick; no other strobes.
- In RUN, pause_pulse and tick_run in the same cycle: cnt_tick=1 and state=2 on the next cycle. Later, pause_pulse and tick_run together in PAUSED: state=1, cnt_tick=0.
- STOP_AT_MAX=1, RUN, at_max=1, tick_run: cnt_tick stays 0 and state=2. Repeat with STOP_AT_MAX=0: cnt_tick=1 and state stays 1.
- adj=1, sel=0, 4 tick_adj: 4 cnt_adj_min pulses. Flip sel=1 between ticks: following ticks give cnt_adj_sec. blink_mask alternates 1100/0000 then 0011/0000 on tick_blink. Drop adj: state=2 with blink_mask=0000.
- clear_pulse in RUN with tick_run in the same cycle: cnt_clr=1, cnt_tick=0, state=0. clear_pulse with adj=1: cnt_clr=1, state=3.
- rst asserted mid-ADJUST with tick_adj in the same cycle: next cycle all outputs 0, state=0, no cnt_adj strobe.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and display blank masks for the stopwatch sequencer
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    ADJUST = 2'd3
  } state_t;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_MIN  = 4'b1100;
  localparam logic [3:0] MASK_SEC  = 4'b0011;
  localparam logic [3:0] MASK_ALL  = 4'b1111;

  // Digits to blank while the blink phase is in its "off" half.
  function automatic logic [3:0] mask_for(input state_t st, input logic phase, input logic sel);
    logic [3:0] m;
    m = MASK_NONE;
    if (phase) begin
      case (st)
        ADJUST:  m = sel ? MASK_SEC : MASK_MIN;
        PAUSED:  m = MASK_ALL;
        default: m = MASK_NONE;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ctrl_blink.sv
// rtl/ctrl_blink.sv - blink phase flop: toggles on the blink tick, cleared whenever the FSM changes state
module ctrl_blink (
  input  logic clk,
  input  logic rst,
  input  logic tick_blink,
  input  logic state_change,
  output logic blink_phase
);

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_phase <= 1'b0;
    end else if (state_change) begin
      blink_phase <= 1'b0;
    end else if (tick_blink) begin
      blink_phase <= ~blink_phase;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - IDLE/RUN/PAUSED/ADJUST sequencer issuing counter strobes and digit blank mask
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter bit STOP_AT_MAX = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause_pulse,
  input  logic       clear_pulse,
  input  logic       adj,
  input  logic       sel,
  input  logic       tick_run,
  input  logic       tick_adj,
  input  logic       tick_blink,
  input  logic       at_max,
  output logic       cnt_tick,
  output logic       cnt_adj_min,
  output logic       cnt_adj_sec,
  output logic       cnt_clr,
  output logic       running,
  output logic [1:0] state,
  output logic [3:0] blink_mask
);

  state_t     state_q;
  state_t     state_nxt;
  logic       tick_nxt;
  logic       min_nxt;
  logic       sec_nxt;
  logic       clr_nxt;
  logic       state_change;
  logic       blink_phase;
  logic       phase_nxt;
  logic [3:0] mask_nxt;

  always_comb begin
    state_nxt = state_q;
    tick_nxt  = 1'b0;
    min_nxt   = 1'b0;
    sec_nxt   = 1'b0;
    clr_nxt   = 1'b0;
    if (clear_pulse) begin
      clr_nxt   = 1'b1;
      state_nxt = adj ? ADJUST : IDLE;
    end else if (adj && (state_q != ADJUST)) begin
      state_nxt = ADJUST;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pause_pulse) state_nxt = RUN;
        end
        RUN: begin
          // A tick landing with the pause press is still counted before pausing.
          if (tick_run) begin
            if (STOP_AT_MAX && at_max) state_nxt = PAUSED;
            else                       tick_nxt  = 1'b1;
          end
          if (pause_pulse) state_nxt = PAUSED;
        end
        PAUSED: begin
          if (pause_pulse) state_nxt = RUN;
        end
        ADJUST: begin
          if (!adj) begin
            state_nxt = PAUSED;
          end else if (tick_adj) begin
            sec_nxt = sel;
            min_nxt = ~sel;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign state_change = (state_nxt != state_q);

  ctrl_blink u_blink (
    .clk          (clk),
    .rst          (rst),
    .tick_blink   (tick_blink),
    .state_change (state_change),
    .blink_phase  (blink_phase)
  );

  // Mask is registered from the post-update phase so a state entry shows all digits at once.
  assign phase_nxt = state_change ? 1'b0 : (blink_phase ^ tick_blink);
  assign mask_nxt  = mask_for(state_nxt, phase_nxt, sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_tick    <= 1'b0;
      cnt_adj_min <= 1'b0;
      cnt_adj_sec <= 1'b0;
      cnt_clr     <= 1'b0;
      running     <= 1'b0;
      blink_mask  <= MASK_NONE;
    end else begin
      state_q     <= state_nxt;
      cnt_tick    <= tick_nxt;
      cnt_adj_min <= min_nxt;
      cnt_adj_sec <= sec_nxt;
      cnt_clr     <= clr_nxt;
      running     <= (state_nxt == RUN);
      blink_mask  <= mask_nxt;
    end
  end

  assign state = state_q;

endmodule
